// File: rtl/cpu_run_monitor_if.sv
// ---------------------------------------------------------------------------
// cpu_run_monitor_if
// Groups the data-memory read port and the dump stream of cpu_run_monitor.
//
// Handshake rules:
//   - mem_rd_en/mem_rd_addr: single-cycle read strobe. mem_rd_data is valid
//     exactly one clock after the cycle in which mem_rd_en was high.
//   - dump_valid/dump_ready: a word transfers on a rising edge where both are
//     high. Once dump_valid rises, dump_data and dump_addr stay stable and
//     dump_valid stays high until that transfer. dump_ready is ignored while
//     dump_valid is low, and the producer never waits on dump_ready before
//     raising dump_valid.
//
// Modports:
//   master - the monitor (drives read strobe/address and the dump stream)
//   slave  - memory + dump consumer side
// ---------------------------------------------------------------------------
interface cpu_run_monitor_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9
);
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [DATA_W-1:0] mem_rd_data;
    logic              dump_valid;
    logic              dump_ready;
    logic [DATA_W-1:0] dump_data;
    logic [ADDR_W-1:0] dump_addr;

    modport master (
        output mem_rd_en,
        output mem_rd_addr,
        input  mem_rd_data,
        output dump_valid,
        input  dump_ready,
        output dump_data,
        output dump_addr
    );

    modport slave (
        input  mem_rd_en,
        input  mem_rd_addr,
        output mem_rd_data,
        input  dump_valid,
        output dump_ready,
        input  dump_data,
        input  dump_addr
    );
endinterface

// File: rtl/cpu_run_monitor.sv
// ---------------------------------------------------------------------------
// cpu_run_monitor
// Run-control and memory-dump engine for the pipelined MIPS CPU. A start
// pulse launches a run; cycles are counted until the MEM/WB finish pulse or
// the watchdog. The CPU is then held and data-memory words 0..DUMP_WORDS-1
// are streamed out one word per two cycles at best.
//
// Ports:
//   clk, reset    - clock, synchronous active-high reset
//   start         - begin a run (IDLE/DONE only)
//   finish_in     - finish pulse from MEM/WB (RUN only)
//   bus           - memory read port + dump stream (cpu_run_monitor_if.master)
//   cpu_hold      - freeze CPU in DUMP_REQ/DUMP_OUT/DONE
//   cycle_count   - cycles spent in RUN (saturating)
//   busy, done    - RUN..DUMP_OUT / DONE
//   timed_out     - sticky watchdog flag for the last run
//   dbg_state     - current FSM state encoding
// ---------------------------------------------------------------------------
module cpu_run_monitor #(
    parameter int DATA_W          = 32,
    parameter int ADDR_W          = 9,
    parameter int DUMP_WORDS      = 512,
    parameter int TIMEOUT_CYCLES  = 300,
    parameter int CNT_W           = 32,
    parameter bit DUMP_ON_TIMEOUT = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                finish_in,
    cpu_run_monitor_if.master   bus,
    output logic                cpu_hold,
    output logic [CNT_W-1:0]    cycle_count,
    output logic                busy,
    output logic                done,
    output logic                timed_out,
    output logic [2:0]          dbg_state
);
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RUN      = 3'd1,
        S_DUMP_REQ = 3'd2,
        S_DUMP_OUT = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0]  TIMEOUT_C = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DUMP_WORDS - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d, count_inc;
    logic              timed_out_q, timed_out_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    // High only in the first DUMP_OUT cycle: the memory's registered read data
    // is on mem_rd_data right then, so it is forwarded and captured at once.
    logic              first_q, first_d;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            timed_out_q <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            first_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            timed_out_q <= timed_out_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            first_q     <= first_d;
        end
    end

    // Saturating increment: the counter sticks at all-ones rather than wrap.
    assign count_inc = (&count_q) ? count_q : count_q + CNT_ONE;

    // Next-state logic
    always_comb begin : next_state
        state_d     = state_q;
        count_d     = count_q;
        timed_out_d = timed_out_q;
        addr_d      = addr_q;
        data_d      = data_q;
        first_d     = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d     = S_RUN;
                    count_d     = '0;
                    timed_out_d = 1'b0;
                end
            end
            S_RUN: begin
                count_d = count_inc;
                // Finish has priority over a watchdog hit in the same cycle.
                if (finish_in) begin
                    state_d = S_DUMP_REQ;
                    addr_d  = '0;
                end else if (count_inc == TIMEOUT_C) begin
                    timed_out_d = 1'b1;
                    addr_d      = '0;
                    state_d     = DUMP_ON_TIMEOUT ? S_DUMP_REQ : S_DONE;
                end
            end
            S_DUMP_REQ: begin
                state_d = S_DUMP_OUT;
                first_d = 1'b1;
            end
            S_DUMP_OUT: begin
                if (first_q) begin
                    data_d = bus.mem_rd_data;
                end
                if (bus.dump_ready) begin
                    if (addr_q == LAST_ADDR) begin
                        state_d = S_DONE;
                    end else begin
                        addr_d  = addr_q + ADDR_ONE;
                        state_d = S_DUMP_REQ;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin : outputs
        cpu_hold       = 1'b0;
        busy           = 1'b0;
        done           = 1'b0;
        bus.mem_rd_en  = 1'b0;
        bus.dump_valid = 1'b0;
        unique case (state_q)
            S_RUN: busy = 1'b1;
            S_DUMP_REQ: begin
                busy          = 1'b1;
                cpu_hold      = 1'b1;
                bus.mem_rd_en = 1'b1;
            end
            S_DUMP_OUT: begin
                busy           = 1'b1;
                cpu_hold       = 1'b1;
                bus.dump_valid = 1'b1;
            end
            S_DONE: begin
                cpu_hold = 1'b1;
                done     = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.mem_rd_addr = addr_q;
    assign bus.dump_addr   = addr_q;
    assign bus.dump_data   = first_q ? bus.mem_rd_data : data_q;
    assign cycle_count     = count_q;
    assign timed_out       = timed_out_q;
    assign dbg_state       = state_q;
endmodule

// File: tb/tb_cpu_run_monitor.sv
// Bench for cpu_run_monitor. Two instances:
//   a: 512-word dump, watchdog 20, dump after timeout
//   b: 8-word dump, watchdog 20, no dump after timeout
// Data memory holds mem[i] = i*3.
module tb_cpu_run_monitor;
  localparam int DW_A = 512;
  localparam int DW_B = 8;
  localparam int TO_CYC = 20;
  localparam bit DOT_A = 1'b1;
  localparam bit DOT_B = 1'b0;
  localparam int SB_W = 41;

  localparam int P_IDLE = 0;
  localparam int P_RUN = 1;
  localparam int P_FETCH = 2;
  localparam int P_SHOW = 3;
  localparam int P_DONE = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst, st, fin, rdy;

  cpu_run_monitor_if #(.DATA_W(32), .ADDR_W(9)) bus_a ();
  cpu_run_monitor_if #(.DATA_W(32), .ADDR_W(9)) bus_b ();
  assign bus_a.dump_ready = rdy[0];
  assign bus_b.dump_ready = rdy[1];

  logic hold_a, busy_a, done_a, to_a, hold_b, busy_b, done_b, to_b;
  logic [31:0] cnt_a, cnt_b;
  logic [2:0] dbg_a, dbg_b;

  cpu_run_monitor #(.DATA_W(32), .ADDR_W(9), .DUMP_WORDS(DW_A), .TIMEOUT_CYCLES(TO_CYC),
                    .CNT_W(32), .DUMP_ON_TIMEOUT(DOT_A)) u_a (
    .clk(clk), .reset(rst[0]), .start(st[0]), .finish_in(fin[0]), .bus(bus_a),
    .cpu_hold(hold_a), .cycle_count(cnt_a), .busy(busy_a), .done(done_a),
    .timed_out(to_a), .dbg_state(dbg_a));

  cpu_run_monitor #(.DATA_W(32), .ADDR_W(9), .DUMP_WORDS(DW_B), .TIMEOUT_CYCLES(TO_CYC),
                    .CNT_W(32), .DUMP_ON_TIMEOUT(DOT_B)) u_b (
    .clk(clk), .reset(rst[1]), .start(st[1]), .finish_in(fin[1]), .bus(bus_b),
    .cpu_hold(hold_b), .cycle_count(cnt_b), .busy(busy_b), .done(done_b),
    .timed_out(to_b), .dbg_state(dbg_b));

  // Synchronous data memory: data one cycle after the strobe, garbage otherwise.
  always @(posedge clk) begin
    bus_a.mem_rd_data <= bus_a.mem_rd_en ? 32'(bus_a.mem_rd_addr) * 32'd3 : 32'hdead_beef;
    bus_b.mem_rd_data <= bus_b.mem_rd_en ? 32'(bus_b.mem_rd_addr) * 32'd3 : 32'hdead_beef;
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  int beats[2];
  bit armed = 1'b0;
  logic [SB_W-1:0] exp_q_a[$];
  logic [SB_W-1:0] exp_q_b[$];

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Phase of a run as seen from outside: idle, running, fetching word idx,
  // showing word idx, finished.
  typedef struct {
    int ph;
    longint cnt;
    bit to;
    int idx;
    bit fresh;   // nothing captured since reset: data/address outputs are 0
  } mdl_t;
  mdl_t m[2];

  task automatic upd(input int k, input bit r, input bit s, input bit f, input bit rd);
    int dw;
    bit dot;
    dw = (k == 0) ? DW_A : DW_B;
    dot = (k == 0) ? DOT_A : DOT_B;
    if (r) begin
      m[k].ph = P_IDLE; m[k].cnt = 0; m[k].to = 1'b0; m[k].idx = 0; m[k].fresh = 1'b1;
      if (k == 0) exp_q_a.delete(); else exp_q_b.delete();
      return;
    end
    case (m[k].ph)
      P_IDLE, P_DONE: if (s) begin m[k].ph = P_RUN; m[k].cnt = 0; m[k].to = 1'b0; end
      P_RUN: begin
        if (m[k].cnt < 64'hffff_ffff) m[k].cnt++;
        if (f || m[k].cnt == TO_CYC) begin
          if (!f) m[k].to = 1'b1;
          if (f || dot) begin
            m[k].ph = P_FETCH;
            m[k].idx = 0;
            for (int i = 0; i < dw; i++) begin
              if (k == 0) exp_q_a.push_back({9'(i), 32'(i * 3)});
              else exp_q_b.push_back({9'(i), 32'(i * 3)});
            end
          end else begin
            m[k].ph = P_DONE;
          end
        end
      end
      P_FETCH: begin m[k].ph = P_SHOW; m[k].fresh = 1'b0; end
      P_SHOW: if (rd) begin
        if (m[k].idx == dw - 1) m[k].ph = P_DONE;
        else begin m[k].idx++; m[k].ph = P_FETCH; end
      end
      default: ;
    endcase
  endtask

  always @(posedge clk) begin
    if (rst != 2'b00) armed = 1'b1;
    upd(0, rst[0], st[0], fin[0], rdy[0]);
    upd(1, rst[1], st[1], fin[1], rdy[1]);
  end

  task automatic chk(input int k, input logic hold, input logic busy, input logic dn,
                     input logic to, input logic [31:0] cnt, input logic en,
                     input logic [8:0] raddr, input logic dv, input logic [31:0] dd,
                     input logic [8:0] da, input logic rd, input logic r);
    int ph;
    string s;
    logic [SB_W-1:0] e;
    ph = m[k].ph;
    s = (k == 0) ? "a" : "b";
    cmp({s, ".cpu_hold"}, 64'(hold), 64'(ph == P_FETCH || ph == P_SHOW || ph == P_DONE));
    cmp({s, ".busy"}, 64'(busy), 64'(ph == P_RUN || ph == P_FETCH || ph == P_SHOW));
    cmp({s, ".done"}, 64'(dn), 64'(ph == P_DONE));
    cmp({s, ".timed_out"}, 64'(to), 64'(m[k].to));
    cmp({s, ".cycle_count"}, 64'(cnt), 64'(m[k].cnt));
    cmp({s, ".mem_rd_en"}, 64'(en), 64'(ph == P_FETCH));
    cmp({s, ".dump_valid"}, 64'(dv), 64'(ph == P_SHOW));
    if (ph == P_FETCH) cmp({s, ".mem_rd_addr"}, 64'(raddr), 64'(m[k].idx));
    if (ph == P_SHOW) begin
      cmp({s, ".dump_data"}, 64'(dd), 64'(m[k].idx * 3));
      cmp({s, ".dump_addr"}, 64'(da), 64'(m[k].idx));
    end
    if (ph == P_IDLE && m[k].fresh) begin
      cmp({s, ".dump_data_rst"}, 64'(dd), 64'd0);
      cmp({s, ".dump_addr_rst"}, 64'(da), 64'd0);
      cmp({s, ".mem_rd_addr_rst"}, 64'(raddr), 64'd0);
    end
    // Accepted beat: checked in order against the expected dump queue.
    if (dv && rd && !r) begin
      beats[k]++;
      if ((k == 0 ? exp_q_a.size() : exp_q_b.size()) == 0) begin
        checks++; errors++;
        $display("FAIL %s.extra_beat: got addr %0d data 0x%0h expected no beat", s, da, dd);
      end else begin
        e = (k == 0) ? exp_q_a.pop_front() : exp_q_b.pop_front();
        cmp({s, ".beat"}, 64'({da, dd}), 64'(e));
      end
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      chk(0, hold_a, busy_a, done_a, to_a, cnt_a, bus_a.mem_rd_en, bus_a.mem_rd_addr,
          bus_a.dump_valid, bus_a.dump_data, bus_a.dump_addr, rdy[0], rst[0]);
      chk(1, hold_b, busy_b, done_b, to_b, cnt_b, bus_b.mem_rd_en, bus_b.mem_rd_addr,
          bus_b.dump_valid, bus_b.dump_data, bus_b.dump_addr, rdy[1], rst[1]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int k);
    st[k] = 1'b1; tick(1); st[k] = 1'b0;
  endtask

  task automatic pulse_fin(input int k);
    fin[k] = 1'b1; tick(1); fin[k] = 1'b0;
  endtask

  task automatic wait_done(input int k, input int budget);
    int n;
    n = 0;
    while (!(k == 0 ? done_a : done_b) && n < budget) begin tick(1); n++; end
    cmp((k == 0) ? "a.wait_done" : "b.wait_done", 64'(k == 0 ? done_a : done_b), 64'd1);
  endtask

  task automatic wait_beat(input int k, input int addr, input int budget);
    int n;
    n = 0;
    while (!((k == 0) ? (bus_a.dump_valid && bus_a.dump_addr == 9'(addr))
                      : (bus_b.dump_valid && bus_b.dump_addr == 9'(addr))) && n < budget) begin
      tick(1); n++;
    end
    cmp((k == 0) ? "a.wait_beat" : "b.wait_beat",
        64'(k == 0 ? bus_a.dump_addr : bus_b.dump_addr), 64'(addr));
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 2'b11; st = 2'b00; fin = 2'b00; rdy = 2'b11;
    tick(3);
    rst = 2'b00;
    cmp("reset.a.cycle_count", 64'(cnt_a), 64'd0);
    cmp("reset.b.busy", 64'(busy_b), 64'd0);

    // finish_in while idle has no effect
    pulse_fin(0);
    tick(1);
    cmp("idle_fin.busy", 64'(busy_a), 64'd0);

    // Test 1: finish on 12th RUN cycle, full 512-word dump
    beats[0] = 0;
    pulse_start(0);
    tick(11);
    fin[0] = 1'b1; tick(1); fin[0] = 1'b0;
    cmp("t1.cycle_count", 64'(cnt_a), 64'd12);
    cmp("t1.timed_out", 64'(to_a), 64'd0);
    wait_done(0, 1200);
    cmp("t1.beats", 64'(beats[0]), 64'd512);

    // Test 2a: watchdog with dump
    beats[0] = 0;
    pulse_start(0);
    wait_done(0, 1300);
    cmp("t2a.cycle_count", 64'(cnt_a), 64'd20);
    cmp("t2a.timed_out", 64'(to_a), 64'd1);
    cmp("t2a.beats", 64'(beats[0]), 64'd512);

    // Test 2b: watchdog without dump
    beats[1] = 0;
    pulse_start(1);
    tick(19);
    cmp("t2b.busy19", 64'(busy_b), 64'd1);
    tick(1);
    cmp("t2b.done", 64'(done_b), 64'd1);
    cmp("t2b.cycle_count", 64'(cnt_b), 64'd20);
    cmp("t2b.timed_out", 64'(to_b), 64'd1);
    tick(2);
    cmp("t2b.beats", 64'(beats[1]), 64'd0);

    // Test 3: finish on the watchdog cycle
    beats[0] = 0;
    pulse_start(0);
    tick(19);
    fin[0] = 1'b1; tick(1); fin[0] = 1'b0;
    cmp("t3.timed_out", 64'(to_a), 64'd0);
    cmp("t3.cycle_count", 64'(cnt_a), 64'd20);
    wait_done(0, 1200);
    cmp("t3.beats", 64'(beats[0]), 64'd512);

    // Test 4: 8-word dump, consumer stalls 5 cycles on beat 3
    beats[1] = 0;
    pulse_start(1);
    tick(3);
    pulse_fin(1);
    wait_beat(1, 3, 50);
    rdy[1] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cmp("t4.stall_addr", 64'(bus_b.dump_addr), 64'd3);
      cmp("t4.stall_data", 64'(bus_b.dump_data), 64'd9);
      tick(1);
    end
    rdy[1] = 1'b1;
    wait_done(1, 100);
    cmp("t4.beats", 64'(beats[1]), 64'd8);

    // Test 5: reset during beat 4
    pulse_start(1);
    tick(2);
    pulse_fin(1);
    wait_beat(1, 4, 50);
    rst[1] = 1'b1; tick(1); rst[1] = 1'b0;
    cmp("t5.cycle_count", 64'(cnt_b), 64'd0);
    cmp("t5.outputs", 64'({hold_b, busy_b, done_b, to_b, bus_b.mem_rd_en, bus_b.dump_valid}), 64'd0);
    cmp("t5.dump_data", 64'(bus_b.dump_data), 64'd0);
    cmp("t5.dump_addr", 64'(bus_b.dump_addr), 64'd0);
    cmp("t5.mem_rd_addr", 64'(bus_b.mem_rd_addr), 64'd0);
    cmp("t5.state", 64'(dbg_b), 64'd0);
    pulse_fin(1);
    tick(1);
    cmp("t5.idle_fin", 64'(busy_b), 64'd0);
    beats[1] = 0;
    pulse_start(1);
    tick(4);
    pulse_fin(1);
    cmp("t5.rerun_count", 64'(cnt_b), 64'd5);
    wait_done(1, 100);
    cmp("t5.beats", 64'(beats[1]), 64'd8);

    // Test 6: start ignored in RUN/DUMP_OUT, finish ignored in DONE, restart
    beats[0] = 0;
    pulse_start(0);
    tick(3);
    pulse_start(0);
    cmp("t6.run_count", 64'(cnt_a), 64'd4);
    pulse_fin(0);
    wait_beat(0, 2, 50);
    pulse_start(0);
    wait_done(0, 1200);
    cmp("t6.count", 64'(cnt_a), 64'd5);
    cmp("t6.beats", 64'(beats[0]), 64'd512);
    pulse_fin(0);
    cmp("t6.done_fin", 64'(done_a), 64'd1);
    pulse_start(0);
    cmp("t6.restart_count", 64'(cnt_a), 64'd0);
    cmp("t6.restart_busy", 64'(busy_a), 64'd1);
    cmp("t6.restart_done", 64'(done_a), 64'd0);
    wait_done(0, 1300);
    cmp("t6.to_count", 64'(cnt_a), 64'd20);
    cmp("t6.to_flag", 64'(to_a), 64'd1);

    tick(2);
    cmp("end.queue_a", 64'(exp_q_a.size()), 64'd0);
    cmp("end.queue_b", 64'(exp_q_b.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
